// File: rtl/reg_file_scoreboard_if.sv
// Bus bundle for reg_file_scoreboard: two read ports, a reserve port,
// a writeback port, flush and the registered busy count.
interface reg_file_scoreboard_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5,
    parameter int TAG_W  = 4
);
    logic [ADDR_W-1:0] ra_addr_i;
    logic [WIDTH-1:0]  ra_data_o;
    logic              ra_busy_o;
    logic [TAG_W-1:0]  ra_tag_o;

    logic [ADDR_W-1:0] rb_addr_i;
    logic [WIDTH-1:0]  rb_data_o;
    logic              rb_busy_o;
    logic [TAG_W-1:0]  rb_tag_o;

    logic              rsv_i;
    logic [ADDR_W-1:0] rsv_addr_i;
    logic [TAG_W-1:0]  rsv_tag_i;

    logic              wb_i;
    logic [ADDR_W-1:0] wb_addr_i;
    logic [TAG_W-1:0]  wb_tag_i;
    logic [WIDTH-1:0]  wb_data_i;

    logic              flush_i;
    logic [ADDR_W:0]   busy_cnt_o;

    // Pipeline side (decode / writeback) drives requests and sees results.
    modport master (
        output ra_addr_i, rb_addr_i,
        output rsv_i, rsv_addr_i, rsv_tag_i,
        output wb_i, wb_addr_i, wb_tag_i, wb_data_i,
        output flush_i,
        input  ra_data_o, ra_busy_o, ra_tag_o,
        input  rb_data_o, rb_busy_o, rb_tag_o,
        input  busy_cnt_o
    );

    modport slave (
        input  ra_addr_i, rb_addr_i,
        input  rsv_i, rsv_addr_i, rsv_tag_i,
        input  wb_i, wb_addr_i, wb_tag_i, wb_data_i,
        input  flush_i,
        output ra_data_o, ra_busy_o, ra_tag_o,
        output rb_data_o, rb_busy_o, rb_tag_o,
        output busy_cnt_o
    );
endinterface

// File: rtl/reg_file_scoreboard.sv
// Register file with per-entry reservation bits and producer tags, two
// combinational read ports. Optional macro REGFILE_BYPASS_EN forwards writeback data to reads.
module reg_file_scoreboard #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int TAG_W  = 4
) (
    input logic                  clk,
    input logic                  rst,
    reg_file_scoreboard_if.slave bus
);
    localparam int              CNT_W   = ADDR_W + 1;
    localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] data_q [DEPTH];
    logic             busy_q [DEPTH];
    logic [TAG_W-1:0] tag_q  [DEPTH];
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Writable entries are 1..DEPTH-1; entry 0 and out-of-range addresses are inert.
    function automatic logic live_addr(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_L) && (a != '0);
    endfunction

    logic rsv_ok, wb_ok, wb_match, rsv_wb_same, cnt_inc, cnt_dec;

    assign rsv_ok      = bus.rsv_i && !bus.flush_i && live_addr(bus.rsv_addr_i);
    assign wb_ok       = bus.wb_i && live_addr(bus.wb_addr_i);
    assign wb_match    = wb_ok && busy_q[bus.wb_addr_i]
                         && (tag_q[bus.wb_addr_i] == bus.wb_tag_i);
    assign rsv_wb_same = rsv_ok && wb_ok && (bus.rsv_addr_i == bus.wb_addr_i);
    assign cnt_inc     = rsv_ok && !busy_q[bus.rsv_addr_i];
    // A same-entry reserve keeps the entry busy, so the clear does not count.
    assign cnt_dec     = wb_match && !rsv_wb_same;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic wr_en, rsv_en, clr_en;

            assign wr_en  = wb_ok && (bus.wb_addr_i == ADDR_W'(gi));
            assign rsv_en = rsv_ok && (bus.rsv_addr_i == ADDR_W'(gi));
            assign clr_en = wr_en && wb_match;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    data_q[gi] <= '0;
                    busy_q[gi] <= 1'b0;
                    tag_q[gi]  <= '0;
                end else begin
                    if (wr_en) begin
                        data_q[gi] <= bus.wb_data_i;
                    end
                    // Flush drops every reservation but keeps the tags.
                    if (bus.flush_i) begin
                        busy_q[gi] <= 1'b0;
                    end else if (rsv_en) begin
                        busy_q[gi] <= 1'b1;
                        tag_q[gi]  <= bus.rsv_tag_i;
                    end else if (clr_en) begin
                        busy_q[gi] <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        cnt_d = cnt_q;
        if (bus.flush_i) begin
            cnt_d = '0;
        end else if (cnt_inc && !cnt_dec) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (cnt_dec && !cnt_inc) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.busy_cnt_o = cnt_q;

    always_comb begin
        bus.ra_data_o = '0;
        bus.ra_busy_o = 1'b0;
        bus.ra_tag_o  = '0;
        if (live_addr(bus.ra_addr_i)) begin
            bus.ra_data_o = data_q[bus.ra_addr_i];
            bus.ra_busy_o = busy_q[bus.ra_addr_i];
            bus.ra_tag_o  = tag_q[bus.ra_addr_i];
`ifdef REGFILE_BYPASS_EN
            if (wb_ok && (bus.wb_addr_i == bus.ra_addr_i)) begin
                bus.ra_data_o = bus.wb_data_i;
                if (wb_match && !rsv_wb_same) begin
                    bus.ra_busy_o = 1'b0;
                end
            end
`endif
        end
    end

    always_comb begin
        bus.rb_data_o = '0;
        bus.rb_busy_o = 1'b0;
        bus.rb_tag_o  = '0;
        if (live_addr(bus.rb_addr_i)) begin
            bus.rb_data_o = data_q[bus.rb_addr_i];
            bus.rb_busy_o = busy_q[bus.rb_addr_i];
            bus.rb_tag_o  = tag_q[bus.rb_addr_i];
`ifdef REGFILE_BYPASS_EN
            if (wb_ok && (bus.wb_addr_i == bus.rb_addr_i)) begin
                bus.rb_data_o = bus.wb_data_i;
                if (wb_match && !rsv_wb_same) begin
                    bus.rb_busy_o = 1'b0;
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Randomised and directed bench for reg_file_scoreboard against an
// array-based model of the register/reservation rules.
module tb_reg_file_scoreboard;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    reg_file_scoreboard_if #(.WIDTH(32), .ADDR_W(5), .TAG_W(4)) bus ();

    reg_file_scoreboard #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .TAG_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_data [32];
    logic        m_busy [32];
    logic [3:0]  m_tag  [32];

    function automatic int m_cnt();
        int n = 0;
        for (int i = 0; i < 32; i++) if (m_busy[i]) n++;
        return n;
    endfunction

    function automatic logic [36:0] m_read(input int a);
        return {m_data[a], m_busy[a], m_tag[a]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_data[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
        end
    endtask

    task automatic model_apply(input logic rv, input logic [4:0] ra, input logic [3:0] rt,
                               input logic wv, input logic [4:0] wa, input logic [3:0] wt,
                               input logic [31:0] wd, input logic fl);
        logic clr;
        clr = 1'b0;
        if (wv && wa != 0) begin
            clr = m_busy[wa] && (m_tag[wa] == wt);
            m_data[wa] = wd;
        end
        if (fl) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        end else begin
            if (clr) m_busy[wa] = 1'b0;
            if (rv && ra != 0) begin
                m_busy[ra] = 1'b1;
                m_tag[ra]  = rt;
            end
        end
    endtask

    task automatic idle();
        bus.rsv_i = 0; bus.rsv_addr_i = 0; bus.rsv_tag_i = 0;
        bus.wb_i = 0; bus.wb_addr_i = 0; bus.wb_tag_i = 0; bus.wb_data_i = 0;
        bus.flush_i = 0;
    endtask

    task automatic step(input logic rv, input logic [4:0] ra, input logic [3:0] rt,
                        input logic wv, input logic [4:0] wa, input logic [3:0] wt,
                        input logic [31:0] wd, input logic fl);
        @(negedge clk);
        bus.rsv_i = rv; bus.rsv_addr_i = ra; bus.rsv_tag_i = rt;
        bus.wb_i = wv; bus.wb_addr_i = wa; bus.wb_tag_i = wt; bus.wb_data_i = wd;
        bus.flush_i = fl;
        @(posedge clk);
        model_apply(rv, ra, rt, wv, wa, wt, wd, fl);
        #1;
        idle();
        $display("txn rsv=%0d/r%0d/t%0d wb=%0d/r%0d/t%0d/%h flush=%0d cnt_model=%0d",
                 rv, ra, rt, wv, wa, wt, wd, fl, m_cnt());
    endtask

    task automatic probe(input logic [4:0] a, input logic [4:0] b);
        bus.ra_addr_i = a;
        bus.rb_addr_i = b;
        #1;
    endtask

    task automatic test_reset();
        idle();
        probe(0, 0);
        model_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int a = 0; a < 32; a++) begin
            probe(5'(a), 5'(31 - a));
            checks++;
            if ({bus.ra_data_o, bus.ra_busy_o, bus.ra_tag_o} !== 37'h0) begin
                failures++;
                $display("FAIL reset_ra r%0d got=%h exp=0", a, {bus.ra_data_o, bus.ra_busy_o, bus.ra_tag_o});
            end
            checks++;
            if ({bus.rb_data_o, bus.rb_busy_o, bus.rb_tag_o} !== 37'h0) begin
                failures++;
                $display("FAIL reset_rb r%0d got=%h exp=0", 31 - a, {bus.rb_data_o, bus.rb_busy_o, bus.rb_tag_o});
            end
        end
        checks++;
        if (bus.busy_cnt_o !== 6'd0) begin
            failures++;
            $display("FAIL reset_cnt got=%0d exp=0", bus.busy_cnt_o);
        end
    endtask

    task automatic test_reserve_wb();
        step(1, 5, 3, 0, 0, 0, 0, 0);
        probe(5, 0);
        checks++;
        if ({bus.ra_data_o, bus.ra_busy_o, bus.ra_tag_o} !== {32'h0, 1'b1, 4'd3}) begin
            failures++;
            $display("FAIL rsv_r5 got=%h exp=%h", {bus.ra_data_o, bus.ra_busy_o, bus.ra_tag_o}, {32'h0, 1'b1, 4'd3});
        end
        checks++;
        if (bus.busy_cnt_o !== 6'd1) begin
            failures++;
            $display("FAIL rsv_r5_cnt got=%0d exp=1", bus.busy_cnt_o);
        end
        step(0, 0, 0, 1, 5, 3, 32'hDEADBEEF, 0);
        probe(0, 5);
        checks++;
        if ({bus.rb_data_o, bus.rb_busy_o, bus.rb_tag_o} !== {32'hDEADBEEF, 1'b0, 4'd3}) begin
            failures++;
            $display("FAIL wb_r5 got=%h exp=%h", {bus.rb_data_o, bus.rb_busy_o, bus.rb_tag_o}, {32'hDEADBEEF, 1'b0, 4'd3});
        end
        checks++;
        if (bus.busy_cnt_o !== 6'd0) begin
            failures++;
            $display("FAIL wb_r5_cnt got=%0d exp=0", bus.busy_cnt_o);
        end
    endtask

    task automatic test_waw();
        step(1, 7, 1, 0, 0, 0, 0, 0);
        step(1, 7, 2, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 7, 1, 32'h11, 0);
        probe(7, 7);
        checks++;
        if ({bus.ra_data_o, bus.ra_busy_o, bus.ra_tag_o} !== {32'h11, 1'b1, 4'd2} || bus.busy_cnt_o !== 6'd1) begin
            failures++;
            $display("FAIL waw_stale got=%h cnt=%0d exp=%h cnt=1",
                     {bus.ra_data_o, bus.ra_busy_o, bus.ra_tag_o}, bus.busy_cnt_o, {32'h11, 1'b1, 4'd2});
        end
        step(0, 0, 0, 1, 7, 2, 32'h22, 0);
        probe(7, 7);
        checks++;
        if ({bus.rb_data_o, bus.rb_busy_o, bus.rb_tag_o} !== {32'h22, 1'b0, 4'd2} || bus.busy_cnt_o !== 6'd0) begin
            failures++;
            $display("FAIL waw_final got=%h cnt=%0d exp=%h cnt=0",
                     {bus.rb_data_o, bus.rb_busy_o, bus.rb_tag_o}, bus.busy_cnt_o, {32'h22, 1'b0, 4'd2});
        end
    endtask

    task automatic test_same_cycle();
        step(1, 9, 4, 0, 0, 0, 0, 0);
        step(1, 9, 4, 1, 9, 4, 32'h55, 0);
        probe(9, 0);
        checks++;
        if ({bus.ra_data_o, bus.ra_busy_o, bus.ra_tag_o} !== {32'h55, 1'b1, 4'd4} || bus.busy_cnt_o !== 6'd1) begin
            failures++;
            $display("FAIL same_cycle_r9 got=%h cnt=%0d exp=%h cnt=1",
                     {bus.ra_data_o, bus.ra_busy_o, bus.ra_tag_o}, bus.busy_cnt_o, {32'h55, 1'b1, 4'd4});
        end
        step(1, 0, 6, 1, 0, 0, 32'hFFFFFFFF, 0);
        probe(0, 9);
        checks++;
        if ({bus.ra_data_o, bus.ra_busy_o, bus.ra_tag_o} !== 37'h0 || bus.busy_cnt_o !== 6'd1) begin
            failures++;
            $display("FAIL r0_write got=%h cnt=%0d exp=0 cnt=1",
                     {bus.ra_data_o, bus.ra_busy_o, bus.ra_tag_o}, bus.busy_cnt_o);
        end
        step(0, 0, 0, 1, 9, 4, 32'h56, 0);
    endtask

    task automatic test_flush();
        step(1, 1, 5, 0, 0, 0, 0, 0);
        step(1, 2, 6, 0, 0, 0, 0, 0);
        step(1, 3, 7, 0, 0, 0, 0, 0);
        checks++;
        if (bus.busy_cnt_o !== 6'd3) begin
            failures++;
            $display("FAIL flush_pre_cnt got=%0d exp=3", bus.busy_cnt_o);
        end
        step(1, 4, 8, 1, 2, 1, 32'h77, 1);
        checks++;
        if (bus.busy_cnt_o !== 6'd0) begin
            failures++;
            $display("FAIL flush_cnt got=%0d exp=0", bus.busy_cnt_o);
        end
        probe(2, 4);
        checks++;
        if (bus.ra_data_o !== 32'h77 || bus.ra_busy_o !== 1'b0 || bus.rb_busy_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_r2_r4 got data=%h busy2=%b busy4=%b exp data=77 busy 0 0",
                     bus.ra_data_o, bus.ra_busy_o, bus.rb_busy_o);
        end
        for (int a = 1; a < 5; a++) begin
            probe(5'(a), 5'(a));
            checks++;
            if ({bus.ra_data_o, bus.ra_busy_o, bus.ra_tag_o} !== m_read(a)) begin
                failures++;
                $display("FAIL flush_entry r%0d got=%h exp=%h", a, {bus.ra_data_o, bus.ra_busy_o, bus.ra_tag_o}, m_read(a));
            end
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_same;
        step(0, 0, 0, 1, 6, 0, 32'h12345678, 0);
        @(negedge clk);
        bus.ra_addr_i = 6; bus.rb_addr_i = 5;
        bus.wb_i = 1; bus.wb_addr_i = 6; bus.wb_tag_i = 0; bus.wb_data_i = 32'hA5A5A5A5;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_same = 32'hA5A5A5A5;
`else
        exp_same = m_data[6];
`endif
        checks++;
        if (bus.ra_data_o !== exp_same || bus.rb_data_o !== m_data[5]) begin
            failures++;
            $display("FAIL bypass_same_cycle got=%h/%h exp=%h/%h", bus.ra_data_o, bus.rb_data_o, exp_same, m_data[5]);
        end
        @(posedge clk);
        model_apply(0, 0, 0, 1, 6, 0, 32'hA5A5A5A5, 0);
        #1;
        idle();
        $display("txn wb r6 data=a5a5a5a5 with same-cycle read of r6");
        probe(6, 6);
        checks++;
        if (bus.ra_data_o !== 32'hA5A5A5A5) begin
            failures++;
            $display("FAIL bypass_next_cycle got=%h exp=a5a5a5a5", bus.ra_data_o);
        end
    endtask

    task automatic test_random();
        logic rv, wv, fl;
        logic [4:0] ra, wa, pa, pb;
        logic [3:0] rt, wt;
        logic [31:0] wd;
        for (int n = 0; n < 400; n++) begin
            rv = 1'($urandom_range(0, 1));
            ra = 5'($urandom_range(0, 31));
            rt = 4'($urandom_range(0, 15));
            wv = 1'($urandom_range(0, 1));
            wa = 5'($urandom_range(0, 31));
            wt = ($urandom_range(0, 2) != 0) ? m_tag[wa] : 4'($urandom_range(0, 15));
            wd = $urandom;
            fl = ($urandom_range(0, 24) == 0);
            if (n % 3 == 0) wa = ra;
            step(rv, ra, rt, wv, wa, wt, wd, fl);
            pa = 5'($urandom_range(0, 31));
            pb = 5'($urandom_range(0, 31));
            probe(pa, pb);
            checks++;
            if ({bus.ra_data_o, bus.ra_busy_o, bus.ra_tag_o} !== m_read(pa)) begin
                failures++;
                $display("FAIL rand_ra n=%0d r%0d got=%h exp=%h", n, pa, {bus.ra_data_o, bus.ra_busy_o, bus.ra_tag_o}, m_read(pa));
            end
            checks++;
            if ({bus.rb_data_o, bus.rb_busy_o, bus.rb_tag_o} !== m_read(pb)) begin
                failures++;
                $display("FAIL rand_rb n=%0d r%0d got=%h exp=%h", n, pb, {bus.rb_data_o, bus.rb_busy_o, bus.rb_tag_o}, m_read(pb));
            end
            checks++;
            if (int'(bus.busy_cnt_o) != m_cnt()) begin
                failures++;
                $display("FAIL rand_cnt n=%0d got=%0d exp=%0d", n, bus.busy_cnt_o, m_cnt());
            end
        end
        for (int a = 0; a < 32; a++) begin
            probe(5'(a), 5'(a));
            checks++;
            if ({bus.ra_data_o, bus.ra_busy_o, bus.ra_tag_o} !== m_read(a)) begin
                failures++;
                $display("FAIL rand_sweep r%0d got=%h exp=%h", a, {bus.ra_data_o, bus.ra_busy_o, bus.ra_tag_o}, m_read(a));
            end
        end
    endtask

    task automatic test_async_reset();
        step(1, 10, 3, 0, 0, 0, 0, 0);
        step(1, 11, 4, 1, 10, 9, 32'hCAFE0001, 0);
        probe(10, 11);
        checks++;
        if (bus.ra_busy_o !== 1'b1 || bus.rb_busy_o !== 1'b1) begin
            failures++;
            $display("FAIL arst_pre got=%b%b exp=11", bus.ra_busy_o, bus.rb_busy_o);
        end
        @(negedge clk);
        #2;
        rst = 1'b0;
        probe(10, 11);
        checks++;
        if ({bus.ra_data_o, bus.ra_busy_o, bus.ra_tag_o, bus.rb_data_o, bus.rb_busy_o, bus.rb_tag_o} !== 74'h0
            || bus.busy_cnt_o !== 6'd0) begin
            failures++;
            $display("FAIL arst_immediate ra=%h rb=%h cnt=%0d exp all 0",
                     {bus.ra_data_o, bus.ra_busy_o, bus.ra_tag_o}, {bus.rb_data_o, bus.rb_busy_o, bus.rb_tag_o}, bus.busy_cnt_o);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        step(1, 12, 5, 0, 0, 0, 0, 0);
        probe(12, 10);
        checks++;
        if ({bus.ra_data_o, bus.ra_busy_o, bus.ra_tag_o} !== m_read(12) || bus.busy_cnt_o !== 6'd1) begin
            failures++;
            $display("FAIL arst_after got=%h cnt=%0d exp=%h cnt=1",
                     {bus.ra_data_o, bus.ra_busy_o, bus.ra_tag_o}, bus.busy_cnt_o, m_read(12));
        end
    endtask

    initial begin
        test_reset();
        test_reserve_wb();
        test_waw();
        test_same_cycle();
        test_flush();
        test_bypass();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
